// File: rtl/instr_fetch_queue.sv
// Fetch front-end: issues one imem read per cycle under a credit limit and buffers
// returned {pc, instr} pairs in a small FIFO ahead of decode; EX redirects flush and refetch.
module instr_fetch_queue #(
  parameter int               PC_W     = 9,
  parameter int               INS_W    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       deq_ready,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INS_W-1:0]           imem_rdata,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INS_W-1:0]           out_instr,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [PC_W-1:0]  fetch_pc_p0;
  logic             vld_p1;
  logic [PC_W-1:0]  pc_p1;

  logic [PC_W-1:0]  fifo_pc  [DEPTH];
  logic [INS_W-1:0] fifo_ins [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic [CW:0]      used;
  logic             do_wr, do_rd;

  // A word in flight already owns a slot, so credits count it; a same-cycle pop does not free one.
  assign used     = {1'b0, count} + {{CW{1'b0}}, vld_p1};
  assign imem_req = reset && !redirect_valid && (used < LIMIT);
  assign do_wr    = vld_p1 && !redirect_valid;
  assign do_rd    = (count != '0) && deq_ready && !redirect_valid;

  assign imem_addr = fetch_pc_p0;
  assign occupancy = count;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]  : '0;
  assign out_instr = out_valid ? fifo_ins[rd_ptr] : '0;

  // Stage p0 -> p1: fetch PC issues a request, response returns next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_p0 <= {redirect_pc[PC_W-1:2], 2'b00};
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= imem_req;
      if (imem_req)
        fetch_pc_p0 <= fetch_pc_p0 + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req)
      pc_p1 <= fetch_pc_p0;
  end

  // Stage p1 -> FIFO: returned word is written at the tail, readable from the next cycle
  always_ff @(posedge clk) begin
    if (do_wr) begin
      fifo_pc[wr_ptr]  <= pc_p1;
      fifo_ins[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
